// File: rtl/irq_ctl_if.sv
// irq_ctl_if: ctl-side signal bundle of the interrupt front-end.
// master = ctl/CPU side, slave = irq_ctl.
interface irq_ctl_if #(
    parameter int NUM_IRQ = 4
);
    logic [NUM_IRQ-1:0] IRQ_IN;
    logic               NMI_IN;
    logic               MASK_WE;
    logic [7:0]         DB;
    logic               I_FLAG;
    logic               ACK;
    logic               VEC_DONE;
    logic               IRQ;
    logic               NMI;
    logic [15:0]        VEC;
    logic [3:0]         SRC;
    logic               BUSY;
    modport master (
        output IRQ_IN, NMI_IN, MASK_WE, DB, I_FLAG, ACK, VEC_DONE,
        input  IRQ, NMI, VEC, SRC, BUSY
    );
    modport slave (
        input  IRQ_IN, NMI_IN, MASK_WE, DB, I_FLAG, ACK, VEC_DONE,
        output IRQ, NMI, VEC, SRC, BUSY
    );
endinterface

// File: rtl/irq_ctl.sv
// irq_ctl: 6502 interrupt front-end; syncs IRQ/NMI lines, masks, prioritises and freezes the vector.
// Define IRQ_EDGE_EN to add per-channel edge-triggered mode (EDGE register, NUM_IRQ<=7).
module irq_ctl #(
    parameter int          NUM_IRQ     = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] VEC_BASE    = 16'hFFE0
) (
    input logic      clk,
    input logic      RST_N,
    irq_ctl_if.slave bus
);
    typedef enum logic {IDLE, SERVICE} state_t;
    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] irq_sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] irq_chain [SYNC_STAGES+1];
    logic [SYNC_STAGES-1:0] nmi_sync_q;
    logic [SYNC_STAGES:0]   nmi_chain;
    logic               nmi_lat_q, nmi_lat_d;
    logic [15:0]        vec_q, vec_d;
    logic [3:0]         src_q, src_d;
    logic [NUM_IRQ-1:0] pend, irq_now;
    logic [15:0]        win_vec;
    logic [3:0]         win_src;
    logic               take, busy;
    // chain[0] is the raw input, chain[SYNC_STAGES] the synchronised value
    always_comb begin
        irq_chain[0] = bus.IRQ_IN;
        for (int k = 0; k < SYNC_STAGES; k++) irq_chain[k+1] = irq_sync_q[k];
    end
    assign nmi_chain = {nmi_sync_q, bus.NMI_IN};
    assign irq_now   = irq_chain[SYNC_STAGES];
    assign busy      = (state_q == SERVICE);
    assign take      = bus.ACK & ~busy;
    // Edges are seen one stage early so the latch sets on the same clock the sync output moves
    assign nmi_lat_d = (nmi_lat_q & ~(take & (win_src == 4'd8)))
                     | (nmi_chain[SYNC_STAGES] & ~nmi_chain[SYNC_STAGES-1]);
`ifdef IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] edge_q, edge_d, elat_q, elat_d, elat_clr, irq_next;
    assign irq_next = irq_chain[SYNC_STAGES-1];
    assign edge_d   = (bus.MASK_WE & bus.DB[7]) ? bus.DB[NUM_IRQ-1:0] : edge_q;
    assign mask_d   = (bus.MASK_WE & ~bus.DB[7]) ? bus.DB[NUM_IRQ-1:0] : mask_q;
    assign elat_clr = {NUM_IRQ{take}} & (NUM_IRQ'(1) << win_src);
    assign elat_d   = (elat_q & ~elat_clr) | (edge_q & irq_next & ~irq_now);
    assign pend     = ((edge_q & elat_q) | (~edge_q & irq_now)) & mask_q;
    always_ff @(posedge clk or negedge RST_N)
        if (!RST_N) begin
            edge_q <= '0;
            elat_q <= '0;
        end else begin
            edge_q <= edge_d;
            elat_q <= elat_d;
        end
`else
    assign mask_d = bus.MASK_WE ? bus.DB[NUM_IRQ-1:0] : mask_q;
    assign pend   = irq_now & mask_q;
`endif
    // Descending scan so the lowest channel wins; NMI overrides all
    always_comb begin
        win_vec = 16'hFFFE;
        win_src = 4'hF;
        for (int k = NUM_IRQ - 1; k >= 0; k--)
            if (pend[k]) begin
                win_vec = VEC_BASE + 16'(2 * k);
                win_src = 4'(k);
            end
        if (nmi_lat_q) begin
            win_vec = 16'hFFFA;
            win_src = 4'd8;
        end
    end
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        src_d   = src_q;
        if (take) begin
            state_d = SERVICE;
            vec_d   = win_vec;
            src_d   = win_src;
        end else if (busy && bus.VEC_DONE) begin
            state_d = IDLE;
            vec_d   = 16'hFFFE;
            src_d   = 4'hF;
        end
    end
    always_ff @(posedge clk or negedge RST_N)
        if (!RST_N) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            nmi_sync_q <= '1;
            nmi_lat_q  <= 1'b0;
            vec_q      <= 16'hFFFE;
            src_q      <= 4'hF;
            for (int k = 0; k < SYNC_STAGES; k++) irq_sync_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            nmi_sync_q <= nmi_chain[SYNC_STAGES-1:0];
            nmi_lat_q  <= nmi_lat_d;
            vec_q      <= vec_d;
            src_q      <= src_d;
            for (int k = 0; k < SYNC_STAGES; k++) irq_sync_q[k] <= irq_chain[k];
        end
    assign bus.IRQ  = |pend & ~bus.I_FLAG & ~busy;
    assign bus.NMI  = nmi_lat_q & ~busy;
    assign bus.VEC  = vec_q;
    assign bus.SRC  = src_q;
    assign bus.BUSY = busy;
endmodule

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl: directed scenarios plus randomized run against a cycle-level reference model.
module tb_irq_ctl;
    localparam int N = 4;
    localparam int S = 2;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    irq_ctl_if #(.NUM_IRQ(N)) bus ();
    irq_ctl #(.NUM_IRQ(N), .SYNC_STAGES(S), .VEC_BASE(16'hFFE0)) dut (.clk(clk), .RST_N(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    // Reference model: inputs delayed S edges through history queues, state kept as plain flags
    logic [N-1:0] irq_hist [$];
    logic         nmi_hist [$];
    logic [N-1:0] m_mask;
    logic         m_nmi, m_busy;
    logic [15:0]  m_vec;
    logic [3:0]   m_src;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_hist = {};
            nmi_hist = {};
            for (int i = 0; i <= S; i++) begin irq_hist.push_back('0); nmi_hist.push_back(1'b1); end
            m_mask = '0; m_nmi = 0; m_busy = 0; m_vec = 16'hFFFE; m_src = 4'hF;
        end else begin
            logic [N-1:0] pend;
            logic clr, fell;
            pend = irq_hist[S-1] & m_mask;
            clr = 0;
            if (bus.ACK && !m_busy) begin
                m_busy = 1; m_vec = 16'hFFFE; m_src = 4'hF;
                if (m_nmi) begin m_vec = 16'hFFFA; m_src = 8; clr = 1; end
                else for (int k = N - 1; k >= 0; k--) if (pend[k]) begin m_vec = 16'hFFE0 + 16'(2 * k); m_src = 4'(k); end
            end else if (m_busy && bus.VEC_DONE) begin
                m_busy = 0; m_vec = 16'hFFFE; m_src = 4'hF;
            end
            irq_hist.push_front(bus.IRQ_IN); void'(irq_hist.pop_back());
            nmi_hist.push_front(bus.NMI_IN); void'(nmi_hist.pop_back());
            fell = nmi_hist[S] && !nmi_hist[S-1];
            m_nmi = (m_nmi && !clr) || fell;
`ifdef IRQ_EDGE_EN
            if (bus.MASK_WE && !bus.DB[7]) m_mask = bus.DB[N-1:0];
`else
            if (bus.MASK_WE) m_mask = bus.DB[N-1:0];
`endif
        end
    end
    task automatic cyc(); @(negedge clk); endtask
    task automatic ack(); bus.ACK = 1; cyc(); bus.ACK = 0; endtask
    task automatic vdone(); bus.VEC_DONE = 1; cyc(); bus.VEC_DONE = 0; endtask
    task automatic wr_mask(input logic [7:0] d); bus.MASK_WE = 1; bus.DB = d; cyc(); bus.MASK_WE = 0; bus.DB = '0; endtask
    task automatic test_reset();
        bus.IRQ_IN = '0; bus.NMI_IN = 1; bus.MASK_WE = 0; bus.DB = '0; bus.I_FLAG = 0; bus.ACK = 0; bus.VEC_DONE = 0;
        rst_n = 0; repeat (3) cyc(); rst_n = 1; cyc();
        checks++; if (bus.IRQ !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus.IRQ); end
        checks++; if (bus.NMI !== 1'b0) begin failures++; $display("FAIL reset_nmi got=%b exp=0", bus.NMI); end
        checks++; if (bus.VEC !== 16'hFFFE) begin failures++; $display("FAIL reset_vec got=%h exp=fffe", bus.VEC); end
        checks++; if (bus.SRC !== 4'hF) begin failures++; $display("FAIL reset_src got=%h exp=f", bus.SRC); end
        checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
        wr_mask(8'h02); bus.IRQ_IN = 4'b0010; repeat (3) cyc(); ack();
        checks++; if (bus.BUSY !== 1'b1 || bus.SRC !== 4'd1) begin failures++; $display("FAIL pre_reset_service got busy=%b src=%h exp busy=1 src=1", bus.BUSY, bus.SRC); end
        #2 rst_n = 0; #1;
        checks++; if ({bus.IRQ, bus.NMI, bus.BUSY} !== 3'b000) begin failures++; $display("FAIL midservice_reset_flags got=%b exp=000", {bus.IRQ, bus.NMI, bus.BUSY}); end
        checks++; if (bus.VEC !== 16'hFFFE || bus.SRC !== 4'hF) begin failures++; $display("FAIL midservice_reset_vec got=%h/%h exp=fffe/f", bus.VEC, bus.SRC); end
        bus.IRQ_IN = '0; cyc(); rst_n = 1; cyc();
        checks++; if (bus.IRQ !== 1'b0) begin failures++; $display("FAIL reset_mask_cleared got=%b exp=0", bus.IRQ); end
    endtask
    task automatic test_mask_priority();
        wr_mask(8'h05); bus.IRQ_IN = 4'b0100; cyc();
        checks++; if (bus.IRQ !== 1'b0) begin failures++; $display("FAIL irq_after_1clk got=%b exp=0", bus.IRQ); end
        cyc();
        checks++; if (bus.IRQ !== 1'b1) begin failures++; $display("FAIL irq_after_2clk got=%b exp=1", bus.IRQ); end
        ack();
        checks++; if (bus.VEC !== 16'hFFE4 || bus.SRC !== 4'd2 || bus.BUSY !== 1'b1) begin failures++; $display("FAIL ack_ch2 got=%h/%h/%b exp=ffe4/2/1", bus.VEC, bus.SRC, bus.BUSY); end
        checks++; if (bus.IRQ !== 1'b0) begin failures++; $display("FAIL irq_masked_by_busy got=%b exp=0", bus.IRQ); end
        bus.IRQ_IN = '0; vdone();
        checks++; if (bus.BUSY !== 1'b0 || bus.VEC !== 16'hFFFE || bus.SRC !== 4'hF) begin failures++; $display("FAIL vec_done_ch2 got=%b/%h/%h exp=0/fffe/f", bus.BUSY, bus.VEC, bus.SRC); end
    endtask
    task automatic test_nmi_priority();
        wr_mask(8'h0F); bus.IRQ_IN = 4'b0011; bus.NMI_IN = 0; cyc();
        checks++; if (bus.NMI !== 1'b0) begin failures++; $display("FAIL nmi_after_1clk got=%b exp=0", bus.NMI); end
        cyc();
        checks++; if (bus.NMI !== 1'b1 || bus.IRQ !== 1'b1) begin failures++; $display("FAIL nmi_irq_after_2clk got=%b%b exp=11", bus.NMI, bus.IRQ); end
        ack();
        checks++; if (bus.VEC !== 16'hFFFA || bus.SRC !== 4'd8) begin failures++; $display("FAIL ack_nmi got=%h/%h exp=fffa/8", bus.VEC, bus.SRC); end
        bus.NMI_IN = 1; vdone();
        checks++; if (bus.NMI !== 1'b0 || bus.IRQ !== 1'b1) begin failures++; $display("FAIL nmi_cleared got nmi=%b irq=%b exp nmi=0 irq=1", bus.NMI, bus.IRQ); end
        ack();
        checks++; if (bus.VEC !== 16'hFFE0 || bus.SRC !== 4'd0) begin failures++; $display("FAIL ack_ch0 got=%h/%h exp=ffe0/0", bus.VEC, bus.SRC); end
        vdone(); bus.IRQ_IN = '0; repeat (3) cyc();
    endtask
    task automatic test_iflag();
        bus.I_FLAG = 1; bus.IRQ_IN = 4'b1111; repeat (4) cyc();
        checks++; if (bus.IRQ !== 1'b0) begin failures++; $display("FAIL iflag_blocks got=%b exp=0", bus.IRQ); end
        bus.NMI_IN = 0; repeat (2) cyc();
        checks++; if (bus.NMI !== 1'b1 || bus.IRQ !== 1'b0) begin failures++; $display("FAIL iflag_nmi got nmi=%b irq=%b exp nmi=1 irq=0", bus.NMI, bus.IRQ); end
        bus.I_FLAG = 0; #1;
        checks++; if (bus.IRQ !== 1'b1) begin failures++; $display("FAIL iflag_release got=%b exp=1", bus.IRQ); end
        cyc(); ack();
        checks++; if (bus.SRC !== 4'd8) begin failures++; $display("FAIL iflag_ack_nmi got=%h exp=8", bus.SRC); end
        bus.NMI_IN = 1; vdone(); bus.IRQ_IN = '0; repeat (3) cyc();
    endtask
    task automatic test_spurious();
        bus.IRQ_IN = 4'b0010; repeat (2) cyc();
        checks++; if (bus.IRQ !== 1'b1) begin failures++; $display("FAIL spur_raise got=%b exp=1", bus.IRQ); end
        bus.IRQ_IN = '0; repeat (2) cyc();
        checks++; if (bus.IRQ !== 1'b0) begin failures++; $display("FAIL spur_drop got=%b exp=0", bus.IRQ); end
        ack();
        checks++; if (bus.VEC !== 16'hFFFE || bus.SRC !== 4'hF || bus.BUSY !== 1'b1) begin failures++; $display("FAIL spur_ack got=%h/%h/%b exp=fffe/f/1", bus.VEC, bus.SRC, bus.BUSY); end
        vdone();
        checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL spur_done got=%b exp=0", bus.BUSY); end
    endtask
    task automatic test_back_to_back();
        bus.IRQ_IN = 4'b1000; repeat (2) cyc();
        bus.ACK = 1; bus.VEC_DONE = 1; cyc(); bus.ACK = 0; bus.VEC_DONE = 0;
        checks++; if (bus.BUSY !== 1'b1 || bus.SRC !== 4'd3 || bus.VEC !== 16'hFFE6) begin failures++; $display("FAIL ack_beats_done got=%b/%h/%h exp=1/3/ffe6", bus.BUSY, bus.SRC, bus.VEC); end
        bus.IRQ_IN = 4'b0001; repeat (2) cyc(); ack();
        checks++; if (bus.SRC !== 4'd3 || bus.VEC !== 16'hFFE6) begin failures++; $display("FAIL ack_while_busy got=%h/%h exp=3/ffe6", bus.SRC, bus.VEC); end
        wr_mask(8'h00);
        checks++; if (bus.SRC !== 4'd3 || bus.BUSY !== 1'b1) begin failures++; $display("FAIL mask_in_service got=%h/%b exp=3/1", bus.SRC, bus.BUSY); end
        vdone();
        checks++; if (bus.BUSY !== 1'b0 || bus.IRQ !== 1'b0) begin failures++; $display("FAIL after_mask0 got busy=%b irq=%b exp 0/0", bus.BUSY, bus.IRQ); end
        bus.IRQ_IN = '0; cyc();
    endtask
`ifdef IRQ_EDGE_EN
    task automatic test_edge();
        wr_mask(8'h81); wr_mask(8'h01);
        bus.IRQ_IN = 4'b0001; cyc(); bus.IRQ_IN = '0; repeat (5) cyc();
        checks++; if (bus.IRQ !== 1'b1) begin failures++; $display("FAIL edge_held got=%b exp=1", bus.IRQ); end
        ack();
        checks++; if (bus.SRC !== 4'd0 || bus.VEC !== 16'hFFE0) begin failures++; $display("FAIL edge_ack got=%h/%h exp=0/ffe0", bus.SRC, bus.VEC); end
        vdone();
        checks++; if (bus.IRQ !== 1'b0) begin failures++; $display("FAIL edge_cleared got=%b exp=0", bus.IRQ); end
    endtask
`endif
    task automatic test_random();
        rst_n = 0; repeat (2) cyc(); rst_n = 1;
        for (int i = 0; i < 3000; i++) begin
            logic e_irq, e_nmi;
            cyc();
            e_irq = (|(irq_hist[S-1] & m_mask)) && !bus.I_FLAG && !m_busy;
            e_nmi = m_nmi && !m_busy;
            checks++; if (bus.IRQ !== e_irq) begin failures++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", i, bus.IRQ, e_irq); end
            checks++; if (bus.NMI !== e_nmi) begin failures++; $display("FAIL rnd_nmi cyc=%0d got=%b exp=%b", i, bus.NMI, e_nmi); end
            checks++; if (bus.VEC !== m_vec) begin failures++; $display("FAIL rnd_vec cyc=%0d got=%h exp=%h", i, bus.VEC, m_vec); end
            checks++; if (bus.SRC !== m_src) begin failures++; $display("FAIL rnd_src cyc=%0d got=%h exp=%h", i, bus.SRC, m_src); end
            checks++; if (bus.BUSY !== m_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, bus.BUSY, m_busy); end
            if ($urandom_range(3) == 0) bus.IRQ_IN = N'($urandom);
            if ($urandom_range(7) == 0) bus.NMI_IN = ~bus.NMI_IN;
            bus.MASK_WE = ($urandom_range(9) == 0);
            bus.DB = 8'($urandom) & 8'h7F;
            if ($urandom_range(7) == 0) bus.I_FLAG = ~bus.I_FLAG;
            bus.ACK = ($urandom_range(5) == 0) && !bus.I_FLAG;
            bus.VEC_DONE = ($urandom_range(3) == 0);
        end
    endtask
    initial begin
        test_reset();
        test_mask_priority();
        test_nmi_priority();
        test_iflag();
        test_spurious();
        test_back_to_back();
`ifdef IRQ_EDGE_EN
        test_edge();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
